// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status encoding and the memory arbiter grant FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of D completions served while instruction fetch waits.
module arb_starve_ctr #(
    parameter int CNT_W      = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sat_o = (cnt_q == MAX_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !sat_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between icache and dcache with a 3-state grant FSM.
// Build option ARB_ROUND_ROBIN_EN replaces fixed D priority + starvation guard with round robin.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);
    arb_state_t state_q, state_d;
    ramstate_t  ram_st;
    logic       d_req;
    logic       i_done;
    logic       d_done;
    logic       i_first;

    assign ram_st = ramstate_t'(ramstate);
    assign d_req  = dREN | dWEN;
    assign i_done = (state_q == IGRANT) && iREN  && (ram_st == ACCESS);
    assign d_done = (state_q == DGRANT) && d_req && (ram_st == ACCESS);
    assign iload  = ramload;
    assign dload  = ramload;

`ifdef ARB_ROUND_ROBIN_EN
    // 0: I was served last, 1: D was served last.
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (i_done)
            last_grant_d = 1'b0;
        else if (d_done)
            last_grant_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            last_grant_q <= 1'b0;
        else
            last_grant_q <= last_grant_d;
    end

    assign i_first = last_grant_q;
`else
    logic starve_sat;

    arb_starve_ctr #(
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .inc_i  (d_done && iREN),
        .clr_i  (i_done || !iREN),
        .sat_o  (starve_sat)
    );

    assign i_first = starve_sat;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Every grant ends in IDLE: on completion, error (implicit retry) or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (iREN && (i_first || !d_req))
                    state_d = IGRANT;
                else if (d_req)
                    state_d = DGRANT;
            end
            IGRANT: begin
                if (!iREN || ram_st == ACCESS || ram_st == ERROR)
                    state_d = IDLE;
            end
            DGRANT: begin
                if (!d_req || ram_st == ACCESS || ram_st == ERROR)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_q)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !i_done;
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !d_done;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; covers the default build or ARB_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;
    localparam int W = 32;
    localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACC = 2'd2, R_ERR = 2'd3;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [W-1:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]   ramstate = R_FREE;
    logic         iwait, dwait, ramREN, ramWEN;
    logic [W-1:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.WORD_W(W), .STARVE_MAX(4), .CNT_W(3)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        iREN = 0; dREN = 0; dWEN = 0; ramstate = R_FREE;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        nRST = 0;
        tick();
        tick();
        nRST = 1;
    endtask

    task automatic test_reset();
        nRST = 0; iREN = 1; dWEN = 1; daddr = 32'h55; dstore = 32'h66; ramstate = R_ACC;
        #1;
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL reset_strobes got REN=%0b WEN=%0b want 0 0", ramREN, ramWEN); end
        checks++; if (ramaddr !== '0 || ramstore !== '0) begin errors++; $display("FAIL reset_bus got addr=%h store=%h want 0 0", ramaddr, ramstore); end
        checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL reset_waits got i=%0b d=%0b want 1 1", iwait, dwait); end
        do_reset();
    endtask

    task automatic test_single_iread();
        do_reset();
        iREN = 1; iaddr = 32'h0000_0040; #1;
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL iread_idle got REN=%0b iwait=%0b want 0 1", ramREN, iwait); end
        for (int k = 0; k < 2; k++) begin
            tick(); ramstate = R_BUSY; #1;
            checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin errors++; $display("FAIL iread_busy%0d got REN=%0b addr=%h iwait=%0b want 1 40 1", k, ramREN, ramaddr, iwait); end
        end
        tick(); ramstate = R_ACC; ramload = 32'hDEAD_BEEF; #1;
        checks++; if (iwait !== 1'b0 || iload !== 32'hDEAD_BEEF || dwait !== 1'b1) begin errors++; $display("FAIL iread_access got iwait=%0b iload=%h dwait=%0b want 0 deadbeef 1", iwait, iload, dwait); end
        tick(); ramstate = R_FREE; #1;
        checks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL iread_after got iwait=%0b REN=%0b want 1 0", iwait, ramREN); end
        iREN = 0;
    endtask

    task automatic test_contention();
        do_reset();
        iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'h1234; #1;
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("FAIL cont_idle got WEN=%0b REN=%0b want 0 0", ramWEN, ramREN); end
        tick(); ramstate = R_ACC; #1;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'h1234) begin errors++; $display("FAIL cont_dgrant got WEN=%0b REN=%0b addr=%h store=%h want 1 0 100 1234", ramWEN, ramREN, ramaddr, ramstore); end
        checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL cont_dwait got d=%0b i=%0b want 0 1", dwait, iwait); end
        tick(); dWEN = 0; ramstate = R_FREE; #1;
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL cont_gap got REN=%0b WEN=%0b want 0 0", ramREN, ramWEN); end
        tick(); ramstate = R_ACC; ramload = 32'hCAFE; #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80 || iwait !== 1'b0 || iload !== 32'hCAFE) begin errors++; $display("FAIL cont_igrant got REN=%0b addr=%h iwait=%0b iload=%h want 1 80 0 cafe", ramREN, ramaddr, iwait, iload); end
        tick(); iREN = 0; ramstate = R_FREE;
    endtask

    // Six grants with both sides requesting; expected_i gives which side each should go to.
    task automatic run_grants(input logic [5:0] expected_i, input string tag);
        do_reset();
        iREN = 1; iaddr = 32'h10; dREN = 1; daddr = 32'h20;
        for (int g = 0; g < 6; g++) begin
            ramstate = R_FREE; #1;
            checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL %s_idle%0d got REN=%0b want 0", tag, g, ramREN); end
            tick(); ramstate = R_ACC; ramload = W'(g); #1;
            checks++;
            if (iwait !== !expected_i[g] || dwait !== expected_i[g] || ramaddr !== (expected_i[g] ? 32'h10 : 32'h20)) begin
                errors++; $display("FAIL %s_grant%0d got iwait=%0b dwait=%0b addr=%h want iwait=%0b", tag, g, iwait, dwait, ramaddr, !expected_i[g]);
            end
            tick();
        end
        iREN = 0; dREN = 0; ramstate = R_FREE;
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        run_grants(6'b101010, "rr");
    endtask
`else
    task automatic test_starvation();
        run_grants(6'b010000, "starve");
    endtask
`endif

    task automatic test_error_abort();
        do_reset();
        dREN = 1; daddr = 32'h200; tick();
        ramstate = R_ERR; #1;
        checks++; if (ramREN !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL err_grant got REN=%0b dwait=%0b want 1 1", ramREN, dwait); end
        tick(); ramstate = R_FREE; #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL err_idle got REN=%0b dwait=%0b want 0 1", ramREN, dwait); end
        tick(); ramstate = R_BUSY; #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200 || dwait !== 1'b1) begin errors++; $display("FAIL err_regrant got REN=%0b addr=%h dwait=%0b want 1 200 1", ramREN, ramaddr, dwait); end
        tick(); ramstate = R_ACC; #1;
        checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL err_retry_done got dwait=%0b want 0", dwait); end
        tick(); dREN = 0; ramstate = R_FREE; tick();
        dREN = 1; tick();
        ramstate = R_BUSY; #1;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL abort_busy got REN=%0b want 1", ramREN); end
        tick(); dREN = 0; #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL abort_drop got REN=%0b dwait=%0b want 0 1", ramREN, dwait); end
        tick(); ramstate = R_ACC; #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL abort_after got REN=%0b dwait=%0b want 0 1", ramREN, dwait); end
        ramstate = R_FREE;
    endtask

    task automatic test_reset_mid();
        do_reset();
        iREN = 1; iaddr = 32'h300; tick();
        ramstate = R_BUSY; #1;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rmid_grant got REN=%0b want 1", ramREN); end
        nRST = 0; #1;
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL rmid_async got REN=%0b i=%0b d=%0b want 0 1 1", ramREN, iwait, dwait); end
        tick(); nRST = 1; ramstate = R_FREE; #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rmid_idle got REN=%0b want 0", ramREN); end
        tick(); #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin errors++; $display("FAIL rmid_reissue got REN=%0b addr=%h want 1 300", ramREN, ramaddr); end
        iREN = 0;
    endtask

    initial begin
        test_reset();
        test_single_iread();
        test_contention();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_starvation();
`endif
        test_error_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between one core's instruction-cache and data-cache request channels.
- Sits between the caches and RAM. It serialises their traffic with a small grant FSM.
- Default policy is fixed data-side priority, with a starvation guard for instruction fetch.
- Gives the pipeline a single ihit/dhit-style completion per transaction.

Parameters:
- WORD_W, 32, data and address width.
- STARVE_MAX, 4, consecutive D-grants completed while I is waiting that force the next grant to I.
- CNT_W, 3, starvation counter width; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  WORD_W  icache address.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  WORD_W  dcache address.
- dstore  in  WORD_W  dcache write data.
- iwait  out  1  low for exactly the completion cycle of an I transaction.
- dwait  out  1  low for exactly the completion cycle of a D transaction.
- iload  out  WORD_W  RAM read data to icache.
- dload  out  WORD_W  RAM read data to dcache.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Reset values:
  - state IDLE, starve_cnt 0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - iwait=dwait=1.
- FSM states: IDLE, IGRANT, DGRANT.
- RAM outputs are combinational from the registered state:
  - IDLE drives no RAM request, giving 1 cycle of arbitration latency.
  - IGRANT drives ramREN=iREN, ramaddr=iaddr.
  - DGRANT drives ramWEN=dWEN, ramREN=dREN & ~dWEN (write wins), ramaddr=daddr, ramstore=dstore.
- IDLE transitions:
  - d_req=(dREN|dWEN).
  - If iREN and (starve_cnt==STARVE_MAX or !d_req), go to IGRANT.
  - Else if d_req, go to DGRANT.
  - Else stay in IDLE.
- Completion in a grant state:
  - When ramstate==ACCESS, the granted side's wait goes low that same cycle and its load equals ramload.
  - Next state is IDLE; there are no back-to-back grants without an IDLE cycle.
- ERROR in a grant state:
  - No completion; wait stays high; next state is IDLE.
  - The request is re-arbitrated if still asserted, which is an implicit retry.
- Abort: if the granted requester's request drops before ACCESS, the RAM strobes drop that cycle and the next state is IDLE.
- iload/dload carry ramload continuously; they are valid only when the matching wait is low.
- The non-granted side's wait is always 1.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each D completion when iREN=1.
  - Clears on I completion or whenever iREN=0.
- Simultaneous iREN and d_req in IDLE with starve_cnt<STARVE_MAX: D wins.
- Reset asserted mid-transaction: strobes drop immediately (async) and the in-flight transaction is lost; requesters must reissue.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Adds a 1-bit last_grant register (reset 0 = I served last).
  - On simultaneous requests in IDLE, the side not served last wins.
  - last_grant updates on every completion.
  - The starvation counter is not instantiated; STARVE_MAX is ignored.
- Undefined: fixed D priority with the starvation counter exactly as above.

Decomposition:
- Shared package (extend cpu_types_pkg):
  - arb_state_t enum {IDLE, IGRANT, DGRANT}.
  - Reuse the existing ramstate_t (FREE, BUSY, ACCESS, ERROR).
- One natural sub-module: arb_starve_ctr, a saturating counter with inc/clr/sat outputs, parameterised by CNT_W and STARVE_MAX.

Test Plan:
- Single I read:
  - Stimulus: iREN=1, iaddr=0x0000_0040; RAM returns BUSY×2 then ACCESS with ramload=0xDEAD_BEEF.
  - Required: ramREN rises 1 cycle after iREN; iwait low for exactly the ACCESS cycle; iload=0xDEAD_BEEF.
- Contention:
  - Stimulus: iREN=1 and dWEN=1 asserted in the same cycle, daddr=0x100, dstore=0x1234.
  - Required: DGRANT first, with ramWEN=1, ramaddr=0x100, ramstore=0x1234; I is granted after the IDLE cycle.
- Starvation (STARVE_MAX=4, macro off):
  - Stimulus: iREN held high, dREN re-asserted continuously.
  - Required: the 5th grant goes to I; starve_cnt returns to 0 after I completes.
- Round robin (macro on):
  - Stimulus: both sides request continuously.
  - Required: grants strictly alternate, starting with D (last_grant reset to I).
- Error and abort:
  - Stimulus 1: ramstate=ERROR during DGRANT.
  - Required 1: dwait stays 1; FSM goes IDLE; the request is re-granted.
  - Stimulus 2: dREN dropped mid-BUSY.
  - Required 2: ramREN drops the same cycle; no dwait pulse.
- Reset mid-transaction:
  - Stimulus: nRST low during IGRANT/BUSY.
  - Required: ramREN=0 immediately; iwait=dwait=1; state IDLE after release.
